// File: rtl/led_display_row_driver_if.sv
// Row-stream types and the valid/ready interface between the pattern generator and the LED row driver.
// The top/bottom half-row colour vectors are indexed by column.
package led_display_row_driver_pkg;
    localparam int unsigned GL_NUM_COL_PIXELS = 32;
    localparam int unsigned GL_ROW_ADDR_W     = 4;

    typedef struct packed {
        logic [GL_NUM_COL_PIXELS-1:0] blue;
        logic [GL_NUM_COL_PIXELS-1:0] green;
        logic [GL_NUM_COL_PIXELS-1:0] red;
    } rgb_half_t;

    typedef struct packed {
        rgb_half_t top;
        rgb_half_t bot;
    } rgb_row_t;

    localparam int unsigned GL_RGB_ROW_W = $bits(rgb_row_t);
endpackage

interface led_display_row_driver_if;
    import led_display_row_driver_pkg::*;

    rgb_row_t                 row_in;
    logic                     row_valid_in;
    logic                     row_ready_out;
    logic [GL_ROW_ADDR_W-1:0] row_address_in;

    modport master (output row_in, output row_valid_in, output row_address_in, input row_ready_out);
    modport slave  (input row_in, input row_valid_in, input row_address_in, output row_ready_out);
endinterface

// File: rtl/led_display_row_driver.sv
// HUB75 row driver: shifts a new row while the previous one stays lit, then blanks, latches and unblanks.
// Optional feature macro: LED_ROW_DRIVER_UNDERRUN_EN adds underrun_count_out.
module led_display_row_driver
    import led_display_row_driver_pkg::*;
#(
    parameter int unsigned CLK_DIV            = 2,
    parameter int unsigned DISPLAY_MIN_CYCLES = 256,
    parameter int unsigned BLANK_CYCLES       = 2
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    led_display_row_driver_if.slave  row_if,
    output logic                     hub_clk_out,
    output logic                     hub_lat_out,
    output logic                     hub_oe_n_out,
    output logic [3:0]               hub_addr_out,
    output logic [2:0]               hub_rgb_top_out,
    output logic [2:0]               hub_rgb_bot_out
`ifdef LED_ROW_DRIVER_UNDERRUN_EN
    ,
    output logic [15:0]              underrun_count_out
`endif
);
    localparam int unsigned N      = GL_NUM_COL_PIXELS;
    localparam int unsigned PH_W   = $clog2(2 * CLK_DIV);
    localparam int unsigned PIX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned BL_W   = $clog2(BLANK_CYCLES + 1);
    localparam int unsigned DISP_W = $clog2(DISPLAY_MIN_CYCLES + 1);

    typedef enum logic [2:0] {ST_IDLE, ST_SHIFT, ST_WAIT, ST_BLANK, ST_LATCH} state_t;

    state_t              state_q, state_d;
    rgb_row_t            shreg_q, shreg_d;
    logic [3:0]          pend_addr_q, pend_addr_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [PIX_W-1:0]    pix_q, pix_d;
    logic [BL_W-1:0]     blank_q, blank_d;
    logic [DISP_W-1:0]   disp_q, disp_d;
    logic                lit_q, lit_d;
    logic                ready_q, ready_d;
    logic                hub_clk_q, hub_clk_d;
    logic                lat_q, lat_d;
    logic                oe_n_q, oe_n_d;
    logic [3:0]          addr_q, addr_d;
    logic [2:0]          top_q, top_d;
    logic [2:0]          bot_q, bot_d;
    logic                handshake_c;
    logic                last_tick_c;
    logic                disp_ok_c;

    assign handshake_c = row_if.row_valid_in && ready_q;
    assign last_tick_c = (pix_q == PIX_W'(N - 1)) && (phase_q == PH_W'(2 * CLK_DIV - 1));
    assign disp_ok_c   = (disp_q >= DISP_W'(DISPLAY_MIN_CYCLES));

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        pend_addr_d = pend_addr_q;
        phase_d     = phase_q;
        pix_d       = pix_q;
        blank_d     = blank_q;
        disp_d      = disp_q;
        lit_d       = lit_q;
        hub_clk_d   = hub_clk_q;
        addr_d      = addr_q;
        top_d       = top_q;
        bot_d       = bot_q;

        unique case (state_q)
            ST_IDLE: begin
                if (handshake_c) begin
                    shreg_d     = row_if.row_in;
                    pend_addr_d = row_if.row_address_in;
                    phase_d     = '0;
                    pix_d       = '0;
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Column N-1 leaves first: present the MSB of each colour vector, then shift left.
                if (phase_q == '0) begin
                    top_d           = {shreg_q.top.blue[N-1], shreg_q.top.green[N-1], shreg_q.top.red[N-1]};
                    bot_d           = {shreg_q.bot.blue[N-1], shreg_q.bot.green[N-1], shreg_q.bot.red[N-1]};
                    shreg_d.top.blue  = shreg_q.top.blue  << 1;
                    shreg_d.top.green = shreg_q.top.green << 1;
                    shreg_d.top.red   = shreg_q.top.red   << 1;
                    shreg_d.bot.blue  = shreg_q.bot.blue  << 1;
                    shreg_d.bot.green = shreg_q.bot.green << 1;
                    shreg_d.bot.red   = shreg_q.bot.red   << 1;
                    hub_clk_d       = 1'b0;
                end
                if (phase_q == PH_W'(CLK_DIV)) begin
                    hub_clk_d = 1'b1;
                end
                if (phase_q == PH_W'(2 * CLK_DIV - 1)) begin
                    phase_d = '0;
                    pix_d   = last_tick_c ? '0 : pix_q + PIX_W'(1);
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
                if (last_tick_c) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                hub_clk_d = 1'b0;
                if (disp_ok_c) begin
                    blank_d = '0;
                    state_d = ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (blank_q == BL_W'(BLANK_CYCLES - 1)) begin
                    state_d = ST_LATCH;
                end else begin
                    blank_d = blank_q + BL_W'(1);
                end
            end
            ST_LATCH: begin
                lit_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Display time accumulates only while a row is actually lit.
        if (state_q == ST_LATCH) begin
            disp_d = '0;
        end else if (!oe_n_q && !disp_ok_c) begin
            disp_d = disp_q + DISP_W'(1);
        end

        ready_d = (state_d == ST_IDLE);
        lat_d   = (state_d == ST_LATCH);
        oe_n_d  = !(lit_d && (state_d != ST_BLANK) && (state_d != ST_LATCH));
        if (state_d == ST_LATCH) begin
            addr_d = pend_addr_q;
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            pend_addr_q <= '0;
            phase_q     <= '0;
            pix_q       <= '0;
            blank_q     <= '0;
            disp_q      <= DISP_W'(DISPLAY_MIN_CYCLES);
            lit_q       <= 1'b0;
            ready_q     <= 1'b0;
            hub_clk_q   <= 1'b0;
            lat_q       <= 1'b0;
            oe_n_q      <= 1'b1;
            addr_q      <= '0;
            top_q       <= '0;
            bot_q       <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            pend_addr_q <= pend_addr_d;
            phase_q     <= phase_d;
            pix_q       <= pix_d;
            blank_q     <= blank_d;
            disp_q      <= disp_d;
            lit_q       <= lit_d;
            ready_q     <= ready_d;
            hub_clk_q   <= hub_clk_d;
            lat_q       <= lat_d;
            oe_n_q      <= oe_n_d;
            addr_q      <= addr_d;
            top_q       <= top_d;
            bot_q       <= bot_d;
        end
    end

    assign row_if.row_ready_out = ready_q;
    assign hub_clk_out          = hub_clk_q;
    assign hub_lat_out          = lat_q;
    assign hub_oe_n_out         = oe_n_q;
    assign hub_addr_out         = addr_q;
    assign hub_rgb_top_out      = top_q;
    assign hub_rgb_bot_out      = bot_q;

`ifdef LED_ROW_DRIVER_UNDERRUN_EN
    // Counts idle clocks where the panel could take a new row but none is offered.
    logic [15:0] underrun_q, underrun_d;

    always_comb begin
        underrun_d = underrun_q;
        if ((state_q == ST_IDLE) && disp_ok_c && !row_if.row_valid_in && (underrun_q != 16'hFFFF)) begin
            underrun_d = underrun_q + 16'd1;
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            underrun_q <= '0;
        end else begin
            underrun_q <= underrun_d;
        end
    end

    assign underrun_count_out = underrun_q;
`endif
endmodule

// File: tb/tb_led_display_row_driver.sv
// Randomized self-checking bench for led_display_row_driver: rows go in, the HUB75 pin activity is logged
// per cycle and compared against pixel order, latch addresses and timing rules derived from the row data.
module tb_led_display_row_driver;
    import led_display_row_driver_pkg::*;

    localparam int unsigned CD   = 2;
    localparam int unsigned DMC  = 256;
    localparam int unsigned BC   = 2;
    localparam int unsigned N    = GL_NUM_COL_PIXELS;
    localparam int unsigned MAXC = 20000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       hub_clk, hub_lat, hub_oe_n;
    logic [3:0] hub_addr;
    logic [2:0] hub_top, hub_bot;
`ifdef LED_ROW_DRIVER_UNDERRUN_EN
    logic [15:0] underrun;
`endif

    always #5 clk = ~clk;

    led_display_row_driver_if ifc ();

    led_display_row_driver #(
        .CLK_DIV(CD), .DISPLAY_MIN_CYCLES(DMC), .BLANK_CYCLES(BC)
    ) dut (
        .clk_in          (clk),
        .reset_in        (rst),
        .row_if          (ifc.slave),
        .hub_clk_out     (hub_clk),
        .hub_lat_out     (hub_lat),
        .hub_oe_n_out    (hub_oe_n),
        .hub_addr_out    (hub_addr),
        .hub_rgb_top_out (hub_top),
        .hub_rgb_bot_out (hub_bot)
`ifdef LED_ROW_DRIVER_UNDERRUN_EN
        ,
        .underrun_count_out (underrun)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int         hs_cyc[$];
    int         rise_cyc[$];
    logic [2:0] rise_top[$];
    logic [2:0] rise_bot[$];
    int         lat_cyc[$];
    logic [3:0] lat_addr[$];
    logic       oe_hist  [MAXC];
    logic       lat_hist [MAXC];
    logic       rdy_hist [MAXC];
    logic [3:0] addr_hist[MAXC];
    logic       prev_clk = 1'b0;

    // Handshakes are judged on the values present at the active edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && ifc.row_valid_in && ifc.row_ready_out) hs_cyc.push_back(cyc + 1);
    end

    always @(negedge clk) begin
        if (cyc < int'(MAXC)) begin
            oe_hist[cyc]   <= hub_oe_n;
            lat_hist[cyc]  <= hub_lat;
            rdy_hist[cyc]  <= ifc.row_ready_out;
            addr_hist[cyc] <= hub_addr;
        end
        prev_clk <= hub_clk;
        if (hub_clk && !prev_clk) begin
            rise_cyc.push_back(cyc);
            rise_top.push_back(hub_top);
            rise_bot.push_back(hub_bot);
        end
        if (hub_lat) begin
            lat_cyc.push_back(cyc);
            lat_addr.push_back(hub_addr);
        end
    end

    function automatic logic [2:0] px(input rgb_half_t h, input int col);
        return {h.blue[col], h.green[col], h.red[col]};
    endfunction

    function automatic rgb_row_t rand_row();
        rgb_row_t r;
        r.top.red   = N'($urandom);
        r.top.green = N'($urandom);
        r.top.blue  = N'($urandom);
        r.bot.red   = N'($urandom);
        r.bot.green = N'($urandom);
        r.bot.blue  = N'($urandom);
        return r;
    endfunction

    task automatic clear_logs();
        @(posedge clk);
        #1;
        hs_cyc.delete();
        rise_cyc.delete();
        rise_top.delete();
        rise_bot.delete();
        lat_cyc.delete();
        lat_addr.delete();
    endtask

    task automatic send_row(input rgb_row_t r, input logic [3:0] a, input bit hold,
                            output int hs_at, output bit ok);
        int n;
        @(negedge clk);
        ifc.row_in         = r;
        ifc.row_address_in = a;
        ifc.row_valid_in   = 1'b1;
        n     = hs_cyc.size();
        ok    = 1'b0;
        hs_at = -1;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            if (hs_cyc.size() > n) begin
                ok    = 1'b1;
                hs_at = hs_cyc[n];
                break;
            end
        end
        if (!hold) begin
            @(negedge clk);
            ifc.row_valid_in = 1'b0;
        end
    endtask

    task automatic wait_latches(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            if (lat_cyc.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        ifc.row_valid_in   = 1'b0;
        ifc.row_in         = '0;
        ifc.row_address_in = '0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (ifc.row_ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ifc.row_ready_out); end
        checks++; if (hub_clk !== 1'b0) begin errors++; $display("FAIL reset_hub_clk got %b want 0", hub_clk); end
        checks++; if (hub_lat !== 1'b0) begin errors++; $display("FAIL reset_lat got %b want 0", hub_lat); end
        checks++; if (hub_oe_n !== 1'b1) begin errors++; $display("FAIL reset_oe_n got %b want 1", hub_oe_n); end
        checks++; if (hub_addr !== 4'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", hub_addr); end
        checks++; if ({hub_top, hub_bot} !== 6'd0) begin errors++; $display("FAIL reset_rgb got %b want 0", {hub_top, hub_bot}); end
`ifdef LED_ROW_DRIVER_UNDERRUN_EN
        checks++; if (underrun !== 16'd0) begin errors++; $display("FAIL reset_underrun got %0d want 0", underrun); end
`endif
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ifc.row_ready_out !== 1'b1) begin errors++; $display("FAIL idle_ready got %b want 1", ifc.row_ready_out); end
        checks++; if (hub_oe_n !== 1'b1) begin errors++; $display("FAIL idle_oe_n_before_first_row got %b want 1", hub_oe_n); end
    endtask

    task automatic test_single_row();
        rgb_row_t r;
        int hs, l, bad;
        bit ok;
        clear_logs();
        r = '0;
        r.top.red = '1;
        send_row(r, 4'd5, 1'b0, hs, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_handshake got timeout want handshake"); end
        wait_latches(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_latch got timeout want latch"); return; end
        checks++; if (rise_cyc.size() != N) begin errors++; $display("FAIL single_rise_count got %0d want %0d", rise_cyc.size(), N); return; end
        bad = 0;
        for (int k = 0; k < int'(N); k++) if (rise_top[k] !== 3'b001 || rise_bot[k] !== 3'b000) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL single_pixels got %0d bad pixels want 0", bad); end
        checks++; if (rise_cyc[0] - hs != int'(1 + CD)) begin errors++; $display("FAIL single_first_rise got %0d want %0d", rise_cyc[0] - hs, 1 + CD); end
        checks++; if (rise_cyc[N-1] - rise_cyc[0] != int'(2 * CD * (N - 1))) begin errors++; $display("FAIL single_rise_span got %0d want %0d", rise_cyc[N-1] - rise_cyc[0], 2 * CD * (N - 1)); end
        l = lat_cyc[0];
        checks++; if (lat_addr[0] !== 4'd5) begin errors++; $display("FAIL single_lat_addr got %0d want 5", lat_addr[0]); end
        checks++; if (addr_hist[l-1] !== 4'd0) begin errors++; $display("FAIL single_addr_before got %0d want 0", addr_hist[l-1]); end
        checks++; if (lat_hist[l+1] !== 1'b0 || lat_hist[l-1] !== 1'b0) begin errors++; $display("FAIL single_lat_width got %b%b%b want 010", lat_hist[l-1], lat_hist[l], lat_hist[l+1]); end
        checks++; if ({oe_hist[l-2], oe_hist[l-1], oe_hist[l]} !== 3'b111) begin errors++; $display("FAIL single_blank got %b want 111", {oe_hist[l-2], oe_hist[l-1], oe_hist[l]}); end
        checks++; if (oe_hist[l+1] !== 1'b0) begin errors++; $display("FAIL single_unblank got %b want 0", oe_hist[l+1]); end
        // First row has no display wait: latch follows the shift plus blanking.
        checks++; if (l - hs < int'(2 * CD * N + BC + 1) || l - hs > int'(2 * CD * N + BC + 2)) begin errors++; $display("FAIL single_hs_to_latch got %0d want %0d..%0d", l - hs, 2 * CD * N + BC + 1, 2 * CD * N + BC + 2); end
    endtask

    task automatic test_column_order();
        rgb_row_t r;
        int hs, bad;
        bit ok;
        clear_logs();
        r = '0;
        r.top.green[0] = 1'b1;
        send_row(r, 4'd7, 1'b0, hs, ok);
        wait_latches(1, ok);
        checks++; if (!ok || rise_cyc.size() != N) begin errors++; $display("FAIL column_rises got %0d want %0d", rise_cyc.size(), N); return; end
        bad = 0;
        for (int k = 0; k < int'(N); k++)
            if (rise_top[k] !== ((k == int'(N) - 1) ? 3'b010 : 3'b000) || rise_bot[k] !== 3'b000) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL column_order got %0d bad pixels want 0", bad); end
        checks++; if (lat_addr[0] !== 4'd7) begin errors++; $display("FAIL column_lat_addr got %0d want 7", lat_addr[0]); end
    endtask

    task automatic test_back_to_back();
        rgb_row_t r1, r2;
        int hs1, hs2, l1, l2, lowc, bad;
        bit ok1, ok2, okl;
        clear_logs();
        r1 = rand_row();
        r2 = rand_row();
        send_row(r1, 4'd1, 1'b0, hs1, ok1);
        send_row(r2, 4'd2, 1'b0, hs2, ok2);
        wait_latches(2, okl);
        checks++; if (!(ok1 && ok2 && okl) || rise_cyc.size() != 2 * N) begin errors++; $display("FAIL b2b_progress got rises %0d latches %0d want %0d 2", rise_cyc.size(), lat_cyc.size(), 2 * N); return; end
        bad = 0;
        for (int k = 0; k < int'(N); k++) begin
            if (rise_top[k] !== px(r1.top, N - 1 - k) || rise_bot[k] !== px(r1.bot, N - 1 - k)) bad++;
            if (rise_top[N+k] !== px(r2.top, N - 1 - k) || rise_bot[N+k] !== px(r2.bot, N - 1 - k)) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_pixels got %0d bad pixels want 0", bad); end
        l1 = lat_cyc[0];
        l2 = lat_cyc[1];
        checks++; if (lat_addr[0] !== 4'd1 || lat_addr[1] !== 4'd2) begin errors++; $display("FAIL b2b_addr got %0d,%0d want 1,2", lat_addr[0], lat_addr[1]); end
        checks++; if (addr_hist[l2-1] !== 4'd1 || addr_hist[l2] !== 4'd2) begin errors++; $display("FAIL b2b_addr_switch got %0d->%0d want 1->2", addr_hist[l2-1], addr_hist[l2]); end
        checks++; if (oe_hist[rise_cyc[N]] !== 1'b0 || oe_hist[rise_cyc[2*N-1]] !== 1'b0) begin errors++; $display("FAIL b2b_lit_during_shift got %b%b want 00", oe_hist[rise_cyc[N]], oe_hist[rise_cyc[2*N-1]]); end
        lowc = 0;
        for (int c = l1 + 1; c < l2; c++) if (oe_hist[c] == 1'b0) lowc++;
        checks++; if (lowc < int'(DMC)) begin errors++; $display("FAIL b2b_display_time got %0d want >=%0d", lowc, DMC); end
        checks++; if (l2 - l1 < int'(DMC + BC + 1)) begin errors++; $display("FAIL b2b_latch_period got %0d want >=%0d", l2 - l1, DMC + BC + 1); end
    endtask

    task automatic test_valid_held();
        rgb_row_t r;
        int hs, n, bad;
        bit ok;
        clear_logs();
        r = rand_row();
        send_row(r, 4'd11, 1'b1, hs, ok);
        wait_latches(3, ok);
        @(negedge clk);
        ifc.row_valid_in = 1'b0;
        n = hs_cyc.size();
        wait_latches(n, ok);
        checks++; if (!ok || n < 3 || lat_cyc.size() != n) begin errors++; $display("FAIL held_captures got %0d captures %0d latches want equal and >=3", n, lat_cyc.size()); return; end
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (lat_cyc[i] <= hs_cyc[i]) bad++;
            if (i + 1 < n && hs_cyc[i+1] <= lat_cyc[i]) bad++;
            for (int c = hs_cyc[i]; c <= lat_cyc[i]; c++) if (rdy_hist[c] !== 1'b0) bad++;
            if (rdy_hist[lat_cyc[i]+1] !== 1'b1) bad++;
            if (lat_addr[i] !== 4'd11) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL held_ready_window got %0d violations want 0", bad); end
        bad = 0;
        for (int k = 0; k < int'(N) * n; k++)
            if (rise_top[k] !== px(r.top, N - 1 - (k % N)) || rise_bot[k] !== px(r.bot, N - 1 - (k % N))) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL held_pixels got %0d bad pixels want 0", bad); end
    endtask

    task automatic test_random_rows();
        rgb_row_t   rows[3];
        logic [3:0] addrs[3];
        int hs, bad;
        bit ok;
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            rows[i]  = rand_row();
            addrs[i] = 4'($urandom_range(0, 15));
            send_row(rows[i], addrs[i], 1'b0, hs, ok);
        end
        wait_latches(3, ok);
        checks++; if (!ok || rise_cyc.size() != 3 * N) begin errors++; $display("FAIL random_progress got rises %0d want %0d", rise_cyc.size(), 3 * N); return; end
        for (int i = 0; i < 3; i++) begin
            bad = 0;
            for (int k = 0; k < int'(N); k++)
                if (rise_top[i*N+k] !== px(rows[i].top, N - 1 - k) || rise_bot[i*N+k] !== px(rows[i].bot, N - 1 - k)) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL random_pixels row %0d got %0d bad pixels want 0", i, bad); end
            checks++; if (lat_addr[i] !== addrs[i]) begin errors++; $display("FAIL random_addr row %0d got %0d want %0d", i, lat_addr[i], addrs[i]); end
        end
    endtask

    task automatic test_reset_mid_shift();
        int hs;
        bit ok;
        clear_logs();
        send_row(rand_row(), 4'd3, 1'b0, hs, ok);
        for (int i = 0; i < 2000 && rise_cyc.size() < 5; i++) @(posedge clk);
        checks++; if (rise_cyc.size() < 5) begin errors++; $display("FAIL midrst_shift_started got %0d rises want >=5", rise_cyc.size()); end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if ({ifc.row_ready_out, hub_clk, hub_lat, hub_oe_n} !== 4'b0001) begin errors++; $display("FAIL midrst_ctrl got %b want 0001", {ifc.row_ready_out, hub_clk, hub_lat, hub_oe_n}); end
        checks++; if ({hub_addr, hub_top, hub_bot} !== 10'd0) begin errors++; $display("FAIL midrst_data got %h want 0", {hub_addr, hub_top, hub_bot}); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_logs();
        repeat (600) @(negedge clk);
        checks++; if (lat_cyc.size() != 0 || rise_cyc.size() != 0) begin errors++; $display("FAIL midrst_no_latch got %0d latches %0d rises want 0 0", lat_cyc.size(), rise_cyc.size()); end
        checks++; if (hub_oe_n !== 1'b1) begin errors++; $display("FAIL midrst_dark got %b want 1", hub_oe_n); end
        send_row(rand_row(), 4'd9, 1'b0, hs, ok);
        wait_latches(1, ok);
        checks++; if (!ok || lat_cyc.size() != 1 || lat_addr[0] !== 4'd9) begin errors++; $display("FAIL midrst_new_latch got %0d latches want 1 with addr 9", lat_cyc.size()); end
    endtask

`ifdef LED_ROW_DRIVER_UNDERRUN_EN
    task automatic test_underrun();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        checks++; if (underrun !== 16'd100) begin errors++; $display("FAIL underrun_count got %0d want 100", underrun); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_row();
        test_column_order();
        test_back_to_back();
        test_valid_held();
        test_random_rows();
        test_reset_mid_shift();
`ifdef LED_ROW_DRIVER_UNDERRUN_EN
        test_underrun();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
